// File: rtl/riscv_multicycle_controller_if.sv
// Control bus between the multicycle main controller and the RV32I datapath.
// The datapath returns decode fields and the ALU zero flag; the controller drives every select and enable.
interface riscv_multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
endinterface

// File: rtl/riscv_multicycle_controller.sv
// Moore FSM main controller for the multicycle RV32I core, plus immediate-format and ALU decoding.
// Instructions take 2-5 cycles; the current state is exported on state_out for debug.
module riscv_multicycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  riscv_multicycle_controller_if.master ctl,
  output logic [STATE_W-1:0]          state_out
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       branch, pc_update, mem_write_raw, ir_write_raw, reg_write_raw;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next    = S_FETCH;
    alu_op        = 2'b00;
    branch        = 1'b0;
    pc_update     = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    ctl.AdrSrc    = 1'b0;
    ctl.ResultSrc = 2'b00;
    ctl.ALUSrcA   = 2'b00;
    ctl.ALUSrcB   = 2'b00;
    case (state)
      S_FETCH: begin
        state_next    = S_DECODE;
        ir_write_raw  = 1'b1;
        ctl.ALUSrcB   = 2'b10;
        ctl.ResultSrc = 2'b10;
        pc_update     = 1'b1;
      end
      S_DECODE: begin
        // Unrecognised opcodes fall back to FETCH and behave as a NOP.
        case (ctl.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_R:         state_next = S_EXECR;
          OP_I:         state_next = S_EXECI;
          OP_BEQ:       state_next = S_BEQ;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_FETCH;
        endcase
        ctl.ALUSrcA = 2'b01;
        ctl.ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        state_next  = (ctl.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        state_next = S_MEMWB;
        ctl.AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ctl.ResultSrc = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        ctl.AdrSrc    = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        state_next  = S_ALUWB;
        ctl.ALUSrcA = 2'b10;
        alu_op      = 2'b10;
      end
      S_EXECI: begin
        state_next  = S_ALUWB;
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b01;
        alu_op      = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        ctl.ALUSrcA = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
      end
      S_JAL: begin
        state_next  = S_ALUWB;
        ctl.ALUSrcA = 2'b01;
        ctl.ALUSrcB = 2'b10;
        pc_update   = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Write enables are held off during reset so an abandoned instruction cannot commit anything.
  assign ctl.PCWrite  = ~rst & ((branch & ctl.Zero) | pc_update);
  assign ctl.MemWrite = ~rst & mem_write_raw;
  assign ctl.IRWrite  = ~rst & ir_write_raw;
  assign ctl.RegWrite = ~rst & reg_write_raw;

  always_comb begin
    case (ctl.op)
      OP_SW:   ctl.ImmSrc = 2'b01;
      OP_BEQ:  ctl.ImmSrc = 2'b10;
      OP_JAL:  ctl.ImmSrc = 2'b11;
      default: ctl.ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ctl.ALUControl = 3'b000;
    case (alu_op)
      2'b01: ctl.ALUControl = 3'b001;
      2'b10: begin
        // op[5] separates R-type from I-type, so addi never decodes as sub.
        case (ctl.funct3)
          3'b000:  ctl.ALUControl = (ctl.op[5] & ctl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ctl.ALUControl = 3'b101;
          3'b110:  ctl.ALUControl = 3'b011;
          3'b111:  ctl.ALUControl = 3'b010;
          default: ctl.ALUControl = 3'b000;
        endcase
      end
      default: ctl.ALUControl = 3'b000;
    endcase
  end

  assign state_out = STATE_W'(state);

endmodule
